// File: rtl/minn_pkg.sv
// Width helpers shared by the Minn detector top and its per-antenna paths.
// Pure compile-time functions; no logic, no flow control.
package minn_pkg;

  function automatic int sum_growth(input int l);
    return (l <= 1) ? 1 : $clog2(l + 1);
  endfunction

  function automatic int prod_width(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int corr_width(input int w, input int l);
    return 2 * w + 1 + sum_growth(l);
  endfunction

  function automatic int energy_width(input int w, input int l);
    return corr_width(w, l);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/minn_sliding_sum.sv
// Add-new/subtract-old running sum over a DEPTH-long circular delay; sum is registered, 1-cycle latency.
// No backpressure: advances on every en, holds otherwise; old_ok masks never-written slots after reset.
module minn_sliding_sum
  import minn_pkg::*;
#(
  parameter int DATA_WIDTH = 25,
  parameter int SUM_WIDTH  = 28,
  parameter int DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        old_ok,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic signed [SUM_WIDTH-1:0]  sum,
  output logic signed [SUM_WIDTH-1:0]  sum_next
);

  localparam int PTRW = ptr_width(DEPTH);
  localparam logic [PTRW-1:0] PTR_LAST = PTRW'(DEPTH - 1);

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];
  logic        [PTRW-1:0]       ptr;
  logic signed [DATA_WIDTH-1:0] old;

  assign old      = old_ok ? mem[ptr] : '0;
  assign sum_next = sum + SUM_WIDTH'(din) - SUM_WIDTH'(old);

  // Memory has no reset so it stays RAM-inferable; stale contents are hidden by old_ok.
  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      sum <= '0;
    end else if (en) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + PTRW'(1);
      sum <= sum_next;
    end
  end

endmodule

// File: rtl/minn_antenna_path_core.sv
// Per-antenna lag-L correlation and energy window sums plus delayed copies; outputs registered, 1-cycle latency.
// No backpressure: one sample per cycle when in_valid, everything holds while in_valid is low.
module minn_antenna_path_core
  import minn_pkg::*;
#(
  parameter  int INPUT_WIDTH  = 12,
  parameter  int QUARTER_LEN  = 512,
  localparam int CORR_WIDTH   = corr_width(INPUT_WIDTH, QUARTER_LEN),
  localparam int ENERGY_WIDTH = energy_width(INPUT_WIDTH, QUARTER_LEN)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic signed [INPUT_WIDTH-1:0] in_i,
  input  logic signed [INPUT_WIDTH-1:0] in_q,
  output logic signed [CORR_WIDTH-1:0]   corr_recent,
  output logic signed [CORR_WIDTH-1:0]   corr_previous,
  output logic signed [ENERGY_WIDTH-1:0] energy_recent,
  output logic signed [ENERGY_WIDTH-1:0] energy_previous,
  output logic signed [ENERGY_WIDTH-1:0] energy_previous2,
  output logic                           taps_valid
);

  localparam int L    = QUARTER_LEN;
  localparam int PW   = prod_width(INPUT_WIDTH);
  localparam int CW   = $clog2(4 * L + 1);
  localparam int SPW  = ptr_width(L);
  localparam int HPW  = ptr_width(2 * L);
  localparam logic [CW-1:0]  CNT_L     = CW'(L);
  localparam logic [CW-1:0]  CNT_2L    = CW'(2 * L);
  localparam logic [CW-1:0]  CNT_4L    = CW'(4 * L);
  localparam logic [SPW-1:0] SPTR_LAST = SPW'(L - 1);
  localparam logic [HPW-1:0] HPTR_LAST = HPW'(2 * L - 1);
  localparam logic [HPW-1:0] HPTR_L    = HPW'(L);

  logic [CW-1:0]  count;
  logic [SPW-1:0] sptr;
  logic [HPW-1:0] hptr, hptr_lag;
  logic           lag_ok, prev2_ok;

  logic signed [INPUT_WIDTH-1:0]  i_mem [L];
  logic signed [INPUT_WIDTH-1:0]  q_mem [L];
  logic signed [CORR_WIDTH-1:0]   corr_mem [2*L];
  logic signed [ENERGY_WIDTH-1:0] energy_mem [2*L];

  logic signed [PW-1:0] cur_i, cur_q, lag_i, lag_q, p_new, e_new;
  logic signed [CORR_WIDTH-1:0]   corr_next;
  logic signed [ENERGY_WIDTH-1:0] energy_next;

  // The count doubles as a "slot has been written since reset" flag for every delay line.
  assign lag_ok   = count >= CNT_L;
  assign prev2_ok = count >= CNT_2L;

  assign cur_i = PW'(in_i);
  assign cur_q = PW'(in_q);
  assign lag_i = lag_ok ? PW'(i_mem[sptr]) : '0;
  assign lag_q = lag_ok ? PW'(q_mem[sptr]) : '0;
  assign p_new = cur_i * lag_i + cur_q * lag_q;
  assign e_new = cur_i * cur_i + cur_q * cur_q;

  // The sum written L accepts ago sits half a buffer away from the write pointer.
  assign hptr_lag = (hptr >= HPTR_L) ? hptr - HPTR_L : hptr + HPTR_L;

  minn_sliding_sum #(
    .DATA_WIDTH(PW), .SUM_WIDTH(CORR_WIDTH), .DEPTH(L)
  ) u_corr_sum (
    .clk(clk), .rst_n(rst_n), .en(in_valid), .old_ok(lag_ok),
    .din(p_new), .sum(corr_recent), .sum_next(corr_next)
  );

  minn_sliding_sum #(
    .DATA_WIDTH(PW), .SUM_WIDTH(ENERGY_WIDTH), .DEPTH(L)
  ) u_energy_sum (
    .clk(clk), .rst_n(rst_n), .en(in_valid), .old_ok(lag_ok),
    .din(e_new), .sum(energy_recent), .sum_next(energy_next)
  );

  always_ff @(posedge clk) begin
    if (in_valid) begin
      i_mem[sptr]      <= in_i;
      q_mem[sptr]      <= in_q;
      corr_mem[hptr]   <= corr_next;
      energy_mem[hptr] <= energy_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count            <= '0;
      sptr             <= '0;
      hptr             <= '0;
      corr_previous    <= '0;
      energy_previous  <= '0;
      energy_previous2 <= '0;
      taps_valid       <= 1'b0;
    end else if (in_valid) begin
      sptr             <= (sptr == SPTR_LAST) ? '0 : sptr + SPW'(1);
      hptr             <= (hptr == HPTR_LAST) ? '0 : hptr + HPW'(1);
      if (count != CNT_4L) count <= count + CW'(1);
      taps_valid       <= count >= (CNT_4L - CW'(1));
      corr_previous    <= prev2_ok ? corr_mem[hptr]       : '0;
      energy_previous  <= lag_ok   ? energy_mem[hptr_lag] : '0;
      energy_previous2 <= prev2_ok ? energy_mem[hptr]     : '0;
    end
  end

endmodule

// File: tb/tb_minn_antenna_path_core.sv
// Bench for minn_antenna_path_core: directed quarter patterns plus random traffic against
// a window-sum reference computed directly from the stored sample history.
module tb_minn_antenna_path_core;
  localparam int W  = 12;
  localparam int L  = 4;
  localparam int SW = 28;
  localparam int VW = 5 * SW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic signed [W-1:0] in_i = '0, in_q = '0;
  logic signed [SW-1:0] corr_recent, corr_previous;
  logic signed [SW-1:0] energy_recent, energy_previous, energy_previous2;
  logic taps_valid;
  logic [VW-1:0] dut_vec;

  int total = 0;
  int bad = 0;
  longint mi[$];
  longint mq[$];

  always #5 clk = ~clk;

  minn_antenna_path_core #(.INPUT_WIDTH(W), .QUARTER_LEN(L)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
    .corr_recent(corr_recent), .corr_previous(corr_previous),
    .energy_recent(energy_recent), .energy_previous(energy_previous),
    .energy_previous2(energy_previous2), .taps_valid(taps_valid)
  );

  assign dut_vec = {corr_recent, corr_previous, energy_recent, energy_previous,
                    energy_previous2, taps_valid};

  function automatic longint xi(input int j);
    if (j < 0 || j >= mi.size()) return 0;
    return mi[j];
  endfunction

  function automatic longint xq(input int j);
    if (j < 0 || j >= mq.size()) return 0;
    return mq[j];
  endfunction

  // Window sums straight from the definitions, zero-filled outside the history.
  function automatic longint corr_at(input int m);
    longint s = 0;
    for (int k = 0; k < L; k++)
      s += xi(m - k) * xi(m - L - k) + xq(m - k) * xq(m - L - k);
    return s;
  endfunction

  function automatic longint energy_at(input int m);
    longint s = 0;
    for (int k = 0; k < L; k++)
      s += xi(m - k) * xi(m - k) + xq(m - k) * xq(m - k);
    return s;
  endfunction

  function automatic logic [VW-1:0] model_vec();
    int n = mi.size() - 1;
    return {SW'(corr_at(n)), SW'(corr_at(n - 2 * L)), SW'(energy_at(n)),
            SW'(energy_at(n - L)), SW'(energy_at(n - 2 * L)), (mi.size() >= 4 * L)};
  endfunction

  task automatic step(input logic v, input int i, input int q);
    @(negedge clk);
    in_valid = v;
    in_i = W'(i);
    in_q = W'(q);
    @(posedge clk);
    if (!rst_n) begin
      mi.delete();
      mq.delete();
    end else if (v) begin
      mi.push_back(longint'(i));
      mq.push_back(longint'(q));
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step(1'b0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(c[0], $urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048);
      total++;
      if (dut_vec !== '0) begin
        bad++;
        $display("FAIL reset_hold cycle=%0d got=%h want=0", c, dut_vec);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 77, -33);
      total++;
      if (dut_vec !== '0) begin
        bad++;
        $display("FAIL reset_release cycle=%0d got=%h want=0", c, dut_vec);
      end
    end
  endtask

  task automatic run_constant(input string tag);
    for (int s = 1; s <= 16; s++) begin
      step(1'b1, 100, 0);
      total++;
      if (dut_vec !== model_vec()) begin
        bad++;
        $display("FAIL %s_model s=%0d got=%h want=%h", tag, s, dut_vec, model_vec());
      end
      if (s == 4) begin
        total++;
        if (energy_recent !== SW'(40000) || corr_recent !== '0) begin
          bad++;
          $display("FAIL %s_s4 got e=%0d c=%0d want e=40000 c=0", tag, energy_recent, corr_recent);
        end
      end
      if (s == 8) begin
        total++;
        if (corr_recent !== SW'(40000)) begin
          bad++;
          $display("FAIL %s_s8 got c=%0d want 40000", tag, corr_recent);
        end
      end
      if (s == 15) begin
        total++;
        if (taps_valid !== 1'b0) begin
          bad++;
          $display("FAIL %s_taps15 got=%b want=0", tag, taps_valid);
        end
      end
      if (s == 16) begin
        total++;
        if (corr_recent !== SW'(40000) || corr_previous !== SW'(40000) ||
            energy_recent !== SW'(40000) || energy_previous !== SW'(40000) ||
            energy_previous2 !== SW'(40000) || taps_valid !== 1'b1) begin
          bad++;
          $display("FAIL %s_s16 got=%h want all 40000 taps 1", tag, dut_vec);
        end
      end
    end
  endtask

  task automatic test_constant();
    apply_reset();
    run_constant("const");
  endtask

  task automatic test_minn_preamble();
    int v;
    apply_reset();
    for (int s = 0; s < 16; s++) begin
      v = (s < 8) ? 50 : -50;
      step(1'b1, v, 0);
    end
    total++;
    if (corr_recent !== SW'(10000) || corr_previous !== SW'(10000) ||
        energy_recent !== SW'(10000) || energy_previous !== SW'(10000) ||
        energy_previous2 !== SW'(10000)) begin
      bad++;
      $display("FAIL minn_preamble got=%h want corr/energies 10000", dut_vec);
    end
  endtask

  task automatic test_sign_flip();
    apply_reset();
    for (int s = 0; s < 8; s++) step(1'b1, (s < 4) ? 50 : -50, 0);
    total++;
    if (corr_recent !== SW'(-10000)) begin
      bad++;
      $display("FAIL sign_flip got=%0d want=-10000", corr_recent);
    end
  endtask

  task automatic test_full_scale_gaps();
    logic [VW-1:0] last;
    apply_reset();
    last = dut_vec;
    for (int c = 0; c < 32; c++) begin
      step(c % 2 == 0, -2048, -2048);
      total++;
      if (c % 2 == 1 && dut_vec !== last) begin
        bad++;
        $display("FAIL gap_hold c=%0d got=%h want=%h", c, dut_vec, last);
      end else if (c % 2 == 0 && dut_vec !== model_vec()) begin
        bad++;
        $display("FAIL full_scale_model c=%0d got=%h want=%h", c, dut_vec, model_vec());
      end
      last = dut_vec;
    end
    total++;
    if (corr_recent !== SW'(33554432) || corr_previous !== SW'(33554432) ||
        energy_recent !== SW'(33554432) || energy_previous !== SW'(33554432) ||
        energy_previous2 !== SW'(33554432) || taps_valid !== 1'b1) begin
      bad++;
      $display("FAIL full_scale_final got=%h want all 33554432", dut_vec);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int s = 0; s < 10; s++) step(1'b1, $urandom_range(0, 4095) - 2048, 300);
    rst_n = 1'b0;
    step(1'b1, 555, 555);
    rst_n = 1'b1;
    total++;
    if (dut_vec !== '0) begin
      bad++;
      $display("FAIL mid_reset_clear got=%h want=0", dut_vec);
    end
    run_constant("post_reset");
  endtask

  task automatic test_random();
    logic v;
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      if (c == 150) begin
        rst_n = 1'b0;
        step(1'b1, 1, 1);
        rst_n = 1'b1;
      end
      v = ($urandom_range(0, 3) != 0);
      step(v, $urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048);
      total++;
      if (dut_vec !== model_vec()) begin
        bad++;
        $display("FAIL random c=%0d got=%h want=%h", c, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_minn_preamble();
    test_sign_flip();
    test_full_scale_gaps();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
